// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with sync tracking and framing-error detection
module tdm_demux4 #(
  parameter int W      = 1,
  parameter bit STRICT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [1:0]   slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] sh0;
  logic [W-1:0] sh1;
  logic [W-1:0] sh2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      locked      <= 1'b0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              sh0    <= din;
              slot   <= 2'd1;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (sync) begin
              // Sync always restarts the frame; off slot 0 the partial frame is dropped.
              sh0  <= din;
              slot <= 2'd1;
              if (slot != 2'd0) sync_err <= 1'b1;
            end else begin
              case (slot)
                2'd0: begin
                  if (STRICT) begin
                    sync_err <= 1'b1;
                    state    <= HUNT;
                    locked   <= 1'b0;
                    slot     <= 2'd0;
                  end else begin
                    sh0  <= din;
                    slot <= 2'd1;
                  end
                end
                2'd1: begin
                  sh1  <= din;
                  slot <= 2'd2;
                end
                2'd2: begin
                  sh2  <= din;
                  slot <= 2'd3;
                end
                default: begin
                  ch0         <= sh0;
                  ch1         <= sh1;
                  ch2         <= sh2;
                  ch3         <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed vector bench for tdm_demux4 (strict and free-run instances)
module tb_tdm_demux4;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] din;

  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         frame_valid, locked, sync_err;
  logic [1:0]   slot;

  logic [W-1:0] n_ch0, n_ch1, n_ch2, n_ch3;
  logic         n_frame_valid, n_locked, n_sync_err;
  logic [1:0]   n_slot;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(W), .STRICT(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
  );

  tdm_demux4 #(.W(W), .STRICT(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch0(n_ch0), .ch1(n_ch1), .ch2(n_ch2), .ch3(n_ch3),
    .frame_valid(n_frame_valid), .locked(n_locked), .sync_err(n_sync_err), .slot(n_slot)
  );

  typedef struct {
    logic       r;
    logic       dv;
    logic       sy;
    logic       d;
    logic [3:0] ch;
    logic       fv;
    logic       lk;
    logic       se;
    logic [1:0] sl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic dv, input logic sy, input logic d,
                     input logic [3:0] ch, input logic fv, input logic lk,
                     input logic se, input logic [1:0] sl);
    vecs.push_back('{r: r, dv: dv, sy: sy, d: d, ch: ch, fv: fv, lk: lk, se: se, sl: sl});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic dv, input logic sy, input logic d);
    rst       = r;
    din_valid = dv;
    sync      = sy;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  int fv_steps[$];

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;

    // Expected ch packs as {ch3,ch2,ch1,ch0}.
    add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 2'd0);
    // Plain frame 1,0,0,0
    add(0, 1, 1, 1, 4'b0000, 0, 1, 0, 2'd1);
    add(0, 1, 0, 0, 4'b0000, 0, 1, 0, 2'd2);
    add(0, 1, 0, 0, 4'b0000, 0, 1, 0, 2'd3);
    add(0, 1, 0, 0, 4'b0001, 1, 1, 0, 2'd0);
    // Same frame with gaps; sync during a gap is ignored
    add(0, 0, 1, 0, 4'b0001, 0, 1, 0, 2'd0);
    add(0, 1, 1, 1, 4'b0001, 0, 1, 0, 2'd1);
    add(0, 0, 0, 1, 4'b0001, 0, 1, 0, 2'd1);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 2'd2);
    add(0, 0, 0, 1, 4'b0001, 0, 1, 0, 2'd2);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 2'd3);
    add(0, 0, 0, 1, 4'b0001, 0, 1, 0, 2'd3);
    add(0, 1, 0, 0, 4'b0001, 1, 1, 0, 2'd0);
    // Back-to-back 1,1,0,0 then 0,0,1,1
    add(0, 1, 1, 1, 4'b0001, 0, 1, 0, 2'd1);
    add(0, 1, 0, 1, 4'b0001, 0, 1, 0, 2'd2);
    add(0, 1, 0, 0, 4'b0001, 0, 1, 0, 2'd3);
    add(0, 1, 0, 0, 4'b0011, 1, 1, 0, 2'd0);
    add(0, 1, 1, 0, 4'b0011, 0, 1, 0, 2'd1);
    add(0, 1, 0, 0, 4'b0011, 0, 1, 0, 2'd2);
    add(0, 1, 0, 1, 4'b0011, 0, 1, 0, 2'd3);
    add(0, 1, 0, 1, 4'b1100, 1, 1, 0, 2'd0);
    // Early sync at slot 2, then frame 1,0,1,0 completes
    add(0, 1, 1, 1, 4'b1100, 0, 1, 0, 2'd1);
    add(0, 1, 0, 1, 4'b1100, 0, 1, 0, 2'd2);
    add(0, 1, 1, 1, 4'b1100, 0, 1, 1, 2'd1);
    add(0, 1, 0, 0, 4'b1100, 0, 1, 0, 2'd2);
    add(0, 1, 0, 1, 4'b1100, 0, 1, 0, 2'd3);
    add(0, 1, 0, 0, 4'b0101, 1, 1, 0, 2'd0);
    // Missing sync at slot 0 drops lock; hunt ignores unsynced words
    add(0, 1, 0, 1, 4'b0101, 0, 0, 1, 2'd0);
    add(0, 1, 0, 1, 4'b0101, 0, 0, 0, 2'd0);
    add(0, 0, 1, 1, 4'b0101, 0, 0, 0, 2'd0);
    add(0, 1, 1, 0, 4'b0101, 0, 1, 0, 2'd1);
    add(0, 1, 0, 1, 4'b0101, 0, 1, 0, 2'd2);
    add(0, 1, 0, 1, 4'b0101, 0, 1, 0, 2'd3);
    add(0, 1, 0, 0, 4'b0110, 1, 1, 0, 2'd0);
    // Reset after slot 2 filled, with a valid slot-3 word presented
    add(0, 1, 1, 1, 4'b0110, 0, 1, 0, 2'd1);
    add(0, 1, 0, 1, 4'b0110, 0, 1, 0, 2'd2);
    add(0, 1, 0, 1, 4'b0110, 0, 1, 0, 2'd3);
    add(1, 1, 0, 1, 4'b0000, 0, 0, 0, 2'd0);
    add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 2'd0);
    add(0, 1, 1, 0, 4'b0000, 0, 1, 0, 2'd1);
    add(0, 1, 0, 0, 4'b0000, 0, 1, 0, 2'd2);
    add(0, 1, 0, 1, 4'b0000, 0, 1, 0, 2'd3);
    add(0, 1, 0, 1, 4'b1100, 1, 1, 0, 2'd0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].dv, vecs[i].sy, vecs[i].d);
      chk($sformatf("v%0d.ch", i), {28'd0, ch3, ch2, ch1, ch0}, {28'd0, vecs[i].ch});
      chk($sformatf("v%0d.frame_valid", i), {31'd0, frame_valid}, {31'd0, vecs[i].fv});
      chk($sformatf("v%0d.locked", i), {31'd0, locked}, {31'd0, vecs[i].lk});
      chk($sformatf("v%0d.sync_err", i), {31'd0, sync_err}, {31'd0, vecs[i].se});
      chk($sformatf("v%0d.slot", i), {30'd0, slot}, {30'd0, vecs[i].sl});
    end

    // Free-run instance: missing sync at slot 0 is taken as slot 0
    apply(1, 0, 0, 0);
    apply(0, 1, 1, 1);
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 0, 0);
    chk("ns.frame1_valid", {31'd0, n_frame_valid}, 32'd1);
    chk("ns.frame1_ch", {28'd0, n_ch3, n_ch2, n_ch1, n_ch0}, 32'h1);
    apply(0, 1, 0, 0);
    chk("ns.nosync_err", {31'd0, n_sync_err}, 32'd0);
    chk("ns.nosync_locked", {31'd0, n_locked}, 32'd1);
    chk("ns.nosync_slot", {30'd0, n_slot}, 32'd1);
    chk("strict.nosync_err", {31'd0, sync_err}, 32'd1);
    chk("strict.nosync_locked", {31'd0, locked}, 32'd0);
    apply(0, 1, 0, 1);
    apply(0, 1, 0, 1);
    chk("ns.no_early_valid", {31'd0, n_frame_valid}, 32'd0);
    apply(0, 1, 0, 0);
    chk("ns.frame2_valid", {31'd0, n_frame_valid}, 32'd1);
    chk("ns.frame2_ch", {28'd0, n_ch3, n_ch2, n_ch1, n_ch0}, 32'h6);

    // Continuous stream: one frame_valid every 4 accepted words
    apply(1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      apply(0, 1, ((k % 4) == 1), k[0]);
      if (frame_valid) fv_steps.push_back(k);
    end
    chk("b2b.pulse_count", fv_steps.size(), 32'd3);
    if (fv_steps.size() == 3) begin
      chk("b2b.first_at", fv_steps[0], 32'd4);
      chk("b2b.gap1", fv_steps[1] - fv_steps[0], 32'd4);
      chk("b2b.gap2", fv_steps[2] - fv_steps[1], 32'd4);
    end
    // Words 9..12 carried 1,0,1,0
    chk("b2b.last_ch", {28'd0, ch3, ch2, ch1, ch0}, 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 mux path: takes a time-division-multiplexed stream carrying 4 channel slots per frame and distributes each slot back onto its own output.
- A sync pulse marks slot 0 of each frame.
- The block tracks slot position, assembles each full frame, and presents all four channels together.
- It flags framing errors and re-hunts for sync after loss of alignment.

Parameters:
- W, default 1, data width per slot (bits on din and on each channel output).
- STRICT, default 1: 1 = a missing sync at slot 0 of a locked frame is an error and drops lock; 0 = free-run on the slot counter and only check sync when it appears.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- din  input  W  TDM data for the current slot.
- din_valid  input  1  din/sync qualify; the slot advances only on cycles with din_valid=1.
- sync  input  1  high together with din_valid on the slot-0 word; ignored when din_valid=0.
- ch0, ch1, ch2, ch3  output  W each  registered channel outputs, updated once per complete frame.
- frame_valid  output  1  one-cycle pulse: ch0..ch3 were just updated.
- locked  output  1  1 in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing error.
- slot  output  2  index of the next expected slot (0..3).

Behaviour:
- Reset (rst=1 at a clock edge) takes priority over all inputs and gives:
  - state=HUNT, slot=0, locked=0;
  - ch0..ch3=0, frame_valid=0, sync_err=0;
  - shadow registers sh0..sh2=0.
- Reset mid-frame discards the partial frame. No frame_valid is produced for it.
- An accepted word is a cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing the frame_valid and sync_err pulses.
- HUNT state:
  - Accepted word with sync=1: store din in sh0, slot<=1, go LOCKED.
  - Accepted word with sync=0: discard it, stay in HUNT, no error.
- LOCKED state, accepted word with sync=0:
  - At slot 1 or 2: store din in sh1 or sh2; slot increments.
  - At slot 3, frame completion, all at the same edge:
    - ch0<=sh0, ch1<=sh1, ch2<=sh2, ch3<=din;
    - frame_valid<=1 for exactly the following cycle;
    - slot wraps to 0.
  - At slot 0 with STRICT=1: sync_err pulse, go HUNT, slot<=0, word discarded.
  - At slot 0 with STRICT=0: word is taken as slot 0 (sh0<=din, slot<=1).
- LOCKED state, accepted word with sync=1:
  - At slot 0: normal frame start (sh0<=din, slot<=1).
  - At slot 1..3: early sync. Pulse sync_err, discard the partial frame, treat this word as the new slot 0 (sh0<=din, slot<=1), stay LOCKED. No frame_valid for the discarded frame. ch0..ch3 hold their previous values.
- Latency: the slot-3 word accepted at edge k makes ch0..ch3 valid and frame_valid=1 during cycle k+1.
- Back-to-back frames with din_valid held high give one frame_valid every 4 cycles.
- ch0..ch3 hold their values between frames and across loss of lock.
- locked and slot are registered state, visible the cycle after the edge that changes them.
- sync_err and frame_valid are never both set by the same edge; the early-sync case produces only sync_err.

Test Plan:
1. Reset, then 4 consecutive valid words (W=1) din=1,0,0,0 with sync on the first -> one cycle after the 4th word: ch0..ch3=1,0,0,0, frame_valid=1 for 1 cycle, locked=1, slot=0.
2. Same frame with din_valid=0 gaps between every word -> identical outputs. frame_valid is asserted only after the 4th valid word, and slot holds during the gaps.
3. Two back-to-back frames 1,1,0,0 then 0,0,1,1 with no gaps -> frame_valid pulses exactly 4 cycles apart. ch3 goes 0 then 1; ch0 goes 1 then 0.
4. Early sync: sync on a word at slot 2 -> sync_err pulses 1 cycle, no frame_valid, ch0..ch3 unchanged, slot=1 next, locked stays 1. The following 3 words complete a frame normally.
5. Missing sync after a complete frame, STRICT=1 -> sync_err pulses, locked=0, and words are ignored until the next sync. Repeat with STRICT=0 -> no error, the next 4 words form a frame.
6. Assert rst after slot 2 is filled -> next cycle ch0..ch3=0, locked=0, slot=0, frame_valid=0. A subsequent sync frame decodes correctly.
